// File: rtl/al_osc_pkg.sv
// al_osc_pkg: shared types for the oscillator standby controller.
// Holds the FSM state enum and synchronizer depth.
package al_osc_pkg;

  typedef enum logic [2:0] {
    ST_WAKE,
    ST_RUN,
    ST_ENTER,
    ST_STDBY,
    ST_FAULT
  } osc_state_t;

  localparam int OSC_SYNC_STAGES = 2;

endpackage

// File: rtl/al_sync_edge.sv
// al_sync_edge: synchronizes an async toggle and flags
// either-polarity transitions as a one-cycle pulse.
module al_sync_edge
  import al_osc_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic edge_o
);

  localparam int MSB = OSC_SYNC_STAGES - 1;

  logic [MSB:0] sync_q;
  logic         hist_q;

  // shift the async input in, keep one history flop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[MSB-1:0], async_i};
      hist_q <= sync_q[MSB];
    end
  end

  assign edge_o = sync_q[MSB] ^ hist_q;

endmodule

// File: rtl/al_osc_stdby_ctrl.sv
// al_osc_stdby_ctrl: oscillator wake/standby handshake and stall watchdog.
// Optional edge counter enabled by AL_OSC_EDGE_CNT_EN.
module al_osc_stdby_ctrl
  import al_osc_pkg::*;
#(
  parameter int WAKE_CYCLES    = 64,
  parameter int MIN_EDGES      = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stdby_req,
  output logic             stdby_ack,
  output logic             osc_dis,
  input  logic             osc_div,
  output logic             osc_ready,
  output logic             osc_fault,
  input  logic             fault_clr,
  output logic [CNT_W-1:0] osc_edge_cnt
);

  localparam int CYC_MAX = WAKE_CYCLES + TIMEOUT_CYCLES;
  localparam int CYC_W   = $clog2(CYC_MAX + 1);
  localparam int EC_W    = $clog2(MIN_EDGES + 1);
  localparam int WD_W    = (TIMEOUT_CYCLES > 1) ?
                           $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [CYC_W-1:0] CYC_RUN = CYC_W'(WAKE_CYCLES - 1);
  localparam logic [CYC_W-1:0] CYC_TO  = CYC_W'(CYC_MAX);
  localparam logic [EC_W-1:0]  EC_MAX  = EC_W'(MIN_EDGES);
  localparam logic [WD_W-1:0]  WD_TO   = WD_W'(TIMEOUT_CYCLES - 1);

  osc_state_t       state_q, state_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [EC_W-1:0]  ec_q, ec_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic             ack_q, dis_q, rdy_q, flt_q;
  logic             edge_s;

  al_sync_edge u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (osc_div),
    .edge_o  (edge_s)
  );

  // state, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_WAKE;
      cyc_q   <= '0;
      ec_q    <= '0;
      wd_q    <= '0;
      ack_q   <= 1'b0;
      dis_q   <= 1'b0;
      rdy_q   <= 1'b0;
      flt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      ec_q    <= ec_d;
      wd_q    <= wd_d;
      ack_q   <= (state_d == ST_STDBY);
      dis_q   <= (state_d == ST_STDBY);
      rdy_q   <= (state_d == ST_RUN);
      flt_q   <= (state_d == ST_FAULT);
    end
  end

  // next state; counters idle at zero outside their own state
  always_comb begin
    state_d = state_q;
    cyc_d   = '0;
    ec_d    = '0;
    wd_d    = '0;
    unique case (state_q)
      ST_WAKE: begin
        cyc_d = cyc_q;
        ec_d  = ec_q;
        if (edge_s && ec_q != EC_MAX) begin
          ec_d = ec_q + EC_W'(1);
        end
        if (stdby_req) begin
          state_d = ST_ENTER;
        end else if (cyc_q >= CYC_RUN && ec_q >= EC_MAX) begin
          state_d = ST_RUN;
        end else if (cyc_q == CYC_TO) begin
          state_d = ST_FAULT;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      ST_RUN: begin
        if (edge_s) begin
          wd_d = '0;
        end else if (wd_q != WD_TO) begin
          wd_d = wd_q + WD_W'(1);
        end else begin
          wd_d = wd_q;
        end
        if (!edge_s && wd_q == WD_TO) begin
          state_d = ST_FAULT;
        end else if (stdby_req) begin
          state_d = ST_ENTER;
        end
      end
      ST_ENTER: begin
        state_d = ST_STDBY;
      end
      ST_STDBY: begin
        if (!stdby_req) begin
          state_d = ST_WAKE;
        end
      end
      ST_FAULT: begin
        if (fault_clr) begin
          state_d = ST_WAKE;
        end
      end
      default: begin
        state_d = ST_WAKE;
      end
    endcase
  end

  assign stdby_ack = ack_q;
  assign osc_dis   = dis_q;
  assign osc_ready = rdy_q;
  assign osc_fault = flt_q;

`ifdef AL_OSC_EDGE_CNT_EN
  logic [CNT_W-1:0] ecnt_q;

  // free-running edge tally while the oscillator is expected to run
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ecnt_q <= '0;
    end else if (edge_s &&
                 (state_q == ST_WAKE || state_q == ST_RUN)) begin
      ecnt_q <= ecnt_q + CNT_W'(1);
    end
  end

  assign osc_edge_cnt = ecnt_q;
`else
  assign osc_edge_cnt = '0;
`endif

endmodule
